// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control path: FSM states,
// opcodes, ALU operation classes and ALU B-operand selects.
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXEC_R    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_TRAP      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

endpackage

// File: rtl/multicycle_control_retire_counter.sv
// Wrapping retired-instruction counter with an increment enable.
module retire_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   count <= '0;
    else if (inc) count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle RV32I core (lw, sw, R-type, beq)
// sharing one ALU and one unified memory port.
module multicycle_control
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             illegal,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instret
);

  state_t state, state_nxt;
  logic   retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    retire     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    alu_op     = ALUOP_ADD;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;

    case (state)
      S_IDLE: if (run) state_nxt = S_FETCH;
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_BOFF;
        case (opcode)
          OP_LOAD, OP_STORE: state_nxt = S_MEM_ADDR;
          OP_RTYPE:          state_nxt = S_EXEC_R;
          OP_BRANCH:         state_nxt = S_BRANCH;
          default:           state_nxt = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_nxt = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_nxt = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        retire  = mem_ready;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        state_nxt = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_BR;
        pc_src    = 1'b1;
        pc_write  = zero;
        retire    = 1'b1;
      end
      S_TRAP:  illegal = 1'b1;
      default: state_nxt = S_IDLE;
    endcase

    // every retire path shares the same run-gated return to FETCH or IDLE
    if (retire) state_nxt = run ? S_FETCH : S_IDLE;
  end

  assign state_o = state;

  retire_counter #(.CNT_W(CNT_W)) u_retire (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (retire),
    .count (instret)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: instruction-level reference model plus directed
// scenarios with literal expectations, then randomized traffic.
module tb_multicycle_control;

  localparam int unsigned TB_CNT_W = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                run, zero, mem_ready;
  logic [6:0]          opcode;
  logic                mem_req, mem_we, iord, ir_write, pc_write, pc_src;
  logic                alu_src_a, reg_write, mem_to_reg, illegal;
  logic [1:0]          alu_src_b, alu_op;
  logic [3:0]          state_o;
  logic [TB_CNT_W-1:0] instret;

  int checks = 0;
  int errors = 0;

  multicycle_control #(.CNT_W(TB_CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .illegal    (illegal),
    .state_o    (state_o),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  logic [13:0] dut_out;
  assign dut_out = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
                    alu_src_b, alu_op, reg_write, mem_to_reg, illegal};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: current step plus the remaining step list of the instruction,
  // decided as a whole once the opcode is known.
  typedef struct packed {
    logic [3:0]          st;
    logic [11:0]         rest;
    logic [1:0]          n;
    logic [TB_CNT_W-1:0] cnt;
  } model_t;

  model_t m = '0;

  function automatic model_t pop(model_t a);
    model_t x = a;
    x.st   = a.rest[3:0];
    x.rest = a.rest >> 4;
    x.n    = a.n - 2'd1;
    return x;
  endfunction

  function automatic model_t model_next(model_t a, logic r, logic mr, logic [6:0] op);
    model_t x = a;
    case (a.st)
      4'd0:  if (r) x.st = 4'd1;
      4'd10: x.st = 4'd10;
      4'd1:  if (mr) x.st = 4'd2;
      4'd2: begin
        case (op)
          7'b0000011: begin x.rest = 12'h543; x.n = 2'd3; end
          7'b0100011: begin x.rest = 12'h063; x.n = 2'd2; end
          7'b0110011: begin x.rest = 12'h087; x.n = 2'd2; end
          7'b1100011: begin x.rest = 12'h009; x.n = 2'd1; end
          default:    begin x.rest = 12'h000; x.n = 2'd0; end
        endcase
        if (x.n == 2'd0) x.st = 4'd10;
        else             x = pop(x);
      end
      default: begin
        if (!((a.st == 4'd4 || a.st == 4'd6) && !mr)) begin
          if (a.n != 2'd0) x = pop(a);
          else begin
            x.cnt = a.cnt + 1'b1;
            x.st  = r ? 4'd1 : 4'd0;
          end
        end
      end
    endcase
    return x;
  endfunction

  function automatic logic [13:0] exp_out(logic [3:0] st, logic mr, logic z);
    logic req = 0, we = 0, io = 0, irw = 0, pcw = 0, pcs = 0, sa = 0;
    logic rw = 0, m2r = 0, ill = 0;
    logic [1:0] sb = 2'b00, op = 2'b00;
    case (st)
      4'd1:  begin req = 1; sb = 2'b01; irw = mr; pcw = mr; end
      4'd2:  sb = 2'b11;
      4'd3:  begin sa = 1; sb = 2'b10; end
      4'd4:  begin req = 1; io = 1; end
      4'd5:  begin rw = 1; m2r = 1; end
      4'd6:  begin req = 1; we = 1; io = 1; end
      4'd7:  begin sa = 1; op = 2'b10; end
      4'd8:  rw = 1;
      4'd9:  begin sa = 1; op = 2'b01; pcs = 1; pcw = z; end
      4'd10: ill = 1;
      default: ;
    endcase
    return {req, we, io, irw, pcw, pcs, sa, sb, op, rw, m2r, ill};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= model_next(m, run, mem_ready, opcode);
  end

  always @(negedge clk) begin
    #2;
    check("model_state", 32'(state_o), 32'(m.st));
    check("model_outputs", 32'(dut_out), 32'(exp_out(m.st, mem_ready, zero)));
    check("model_instret", 32'(instret), 32'(m.cnt));
  end

  int trace[$];
  int ir_cnt, req_drop;
  logic pcw_br;

  // Entered at a negedge with the DUT in FETCH; returns at the negedge after
  // the instruction ends (back in IDLE/FETCH, or in TRAP).
  task automatic do_instr(input logic [6:0] op, input int fs_in, input int ms_in,
                          input logic run_v, input logic z_v, output int cyc);
    int fs = fs_in;
    int ms = ms_in;
    logic [3:0] st;
    cyc = 0; ir_cnt = 0; req_drop = 0;
    for (int k = 0; k < 50; k++) begin
      st = state_o;
      opcode = op; run = run_v; zero = z_v;
      if (st == 4'd1) begin mem_ready = (fs == 0); if (fs > 0) fs--; end
      else if (st == 4'd4 || st == 4'd6) begin mem_ready = (ms == 0); if (ms > 0) ms--; end
      else if (st == 4'd2) mem_ready = 1'b1;
      else mem_ready = 1'($urandom_range(0, 1));
      #1;
      trace.push_back(int'(st));
      cyc++;
      if (ir_write) ir_cnt++;
      if ((st == 4'd1 || st == 4'd4 || st == 4'd6) && !mem_req) req_drop++;
      if (st == 4'd9) pcw_br = pc_write;
      @(negedge clk);
      if (st != 4'd1 && (state_o == 4'd0 || state_o == 4'd1 || state_o == 4'd10)) break;
    end
  endtask

  function automatic logic [6:0] rand_op();
    case ($urandom_range(0, 3))
      0:       return 7'b0000011;
      1:       return 7'b0100011;
      2:       return 7'b0110011;
      default: return 7'b1100011;
    endcase
  endfunction

  int cyc, base, bad, k;
  int cycs[4];
  int exp_tr[16] = '{1,2,7,8, 1,2,3,4,5, 1,2,3,6, 1,2,9};
  int exp_cyc[4] = '{4, 5, 4, 3};
  logic saw_wb;

  initial begin
    rst_n = 1'b0; run = 1'b0; opcode = '0; mem_ready = 1'b0; zero = 1'b0;
    pcw_br = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // reset and idle
    repeat (5) @(negedge clk);
    #1;
    check("idle_state", 32'(state_o), 32'd0);
    check("idle_outputs", 32'(dut_out), 32'd0);
    check("idle_instret", 32'(instret), 32'd0);
    run = 1'b1;
    @(posedge clk); #1;
    check("first_fetch_state", 32'(state_o), 32'd1);
    check("first_fetch_req", 32'(mem_req), 32'd1);
    check("first_fetch_iord", 32'(iord), 32'd0);
    @(negedge clk);

    // zero-wait add, lw, sw, beq
    trace.delete();
    base = int'(instret);
    do_instr(7'b0110011, 0, 0, 1'b1, 1'b1, cycs[0]);
    do_instr(7'b0000011, 0, 0, 1'b1, 1'b1, cycs[1]);
    do_instr(7'b0100011, 0, 0, 1'b1, 1'b1, cycs[2]);
    do_instr(7'b1100011, 0, 0, 1'b0, 1'b1, cycs[3]);
    check("zw_trace_len", 32'(trace.size()), 32'd16);
    bad = 0;
    for (int i = 0; i < 16 && i < trace.size(); i++) if (trace[i] != exp_tr[i]) bad++;
    check("zw_trace", 32'(bad), 32'd0);
    for (int i = 0; i < 4; i++) check("zw_cycles", 32'(cycs[i]), 32'(exp_cyc[i]));
    check("zw_instret", 32'(instret), 32'((base + 4) % 16));
    check("zw_branch_pcw", 32'(pcw_br), 32'd1);
    check("zw_end_idle", 32'(state_o), 32'd0);

    // stalled lw: 3 fetch stalls, 2 read stalls, ready pulse in DECODE
    run = 1'b1;
    @(negedge clk);
    do_instr(7'b0000011, 3, 2, 1'b0, 1'b0, cyc);
    check("stall_cycles", 32'(cyc), 32'd10);
    check("stall_ir_pulses", 32'(ir_cnt), 32'd1);
    check("stall_req_held", 32'(req_drop), 32'd0);

    // illegal opcode
    run = 1'b1;
    @(negedge clk);
    base = int'(instret);
    do_instr(7'b0010011, 0, 0, 1'b1, 1'b0, cyc);
    run = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      run = 1'($urandom_range(0, 1));
      #1;
      if (!illegal || state_o != 4'd10 || int'(instret) != base) bad++;
      @(negedge clk);
    end
    check("trap_sticky", 32'(bad), 32'd0);
    rst_n = 1'b0; #1;
    check("trap_cleared", 32'(illegal), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // reset during a stalled MEM_WRITE
    run = 1'b1; opcode = 7'b0100011; mem_ready = 1'b1;
    for (k = 0; k < 20 && state_o != 4'd6; k++) @(negedge clk);
    check("reach_mem_write", 32'(state_o), 32'd6);
    mem_ready = 1'b0; #1;
    check("mw_req_before", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0; #1;
    check("mw_reset_req", 32'(mem_req), 32'd0);
    check("mw_reset_state", 32'(state_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // drop run during EXEC_R
    run = 1'b1; opcode = 7'b0110011; mem_ready = 1'b1;
    base = int'(instret);
    saw_wb = 1'b0;
    @(negedge clk);
    for (k = 0; k < 20; k++) begin
      if (state_o == 4'd7) run = 1'b0;
      if (state_o == 4'd8) saw_wb = 1'b1;
      @(negedge clk);
      if (state_o == 4'd0) break;
    end
    check("rundrop_wb", 32'(saw_wb), 32'd1);
    check("rundrop_idle", 32'(state_o), 32'd0);
    check("rundrop_instret", 32'(instret), 32'((base + 1) % 16));

    // counter wrap: 17 branches from reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; run = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 17; i++)
      do_instr(7'b1100011, 0, 0, (i < 16), 1'($urandom_range(0, 1)), cyc);
    check("wrap_instret", 32'(instret), 32'd1);
    check("wrap_idle", 32'(state_o), 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      mem_ready = ($urandom_range(0, 3) != 0);
      zero      = 1'($urandom_range(0, 1));
      run       = ($urandom_range(0, 7) != 0);
      if (m.st == 4'd0 || m.st == 4'd1) opcode = rand_op();
      @(negedge clk);
    end

    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multi-cycle RV32I core. It sequences fetch, decode, execute, memory and writeback for lw, sw, R-type and beq over a shared ALU and a single unified memory port. It drives the 2-bit alu_op consumed by the ALU control decoder, the datapath mux selects and enables, and the memory request handshake. It also counts retired instructions.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- run  in  1  permit fetching a new instruction
- opcode  in  7  IR[6:0], valid from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  write request (valid with mem_req)
- iord  out  1  address select: 0 = PC, 1 = ALUOut
- ir_write  out  1  load IR from memory read data
- pc_write  out  1  load PC
- pc_src  out  1  PC source: 0 = ALU result, 1 = ALUOut
- alu_src_a  out  1  0 = PC, 1 = reg A
- alu_src_b  out  2  00 = reg B, 01 = constant 4, 10 = imm, 11 = branch offset
- alu_op  out  2  00 = add, 01 = branch subtract, 10 = funct-decoded
- reg_write  out  1  register file write enable
- mem_to_reg  out  1  writeback source: 0 = ALUOut, 1 = MDR
- illegal  out  1  sticky unsupported-opcode flag
- state_o  out  4  current state encoding (debug)
- instret  out  CNT_W  retired-instruction count

## Operation
- States and encodings: IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_READ 4, MEM_WB 5, MEM_WRITE 6, EXEC_R 7, ALU_WB 8, BRANCH 9, TRAP 10.
- Default for all outputs is 0. Any output not listed for a state is 0.
- IDLE: go to FETCH when run = 1.
- FETCH: mem_req = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00. While mem_ready = 0, stay in FETCH. On the mem_ready cycle: ir_write = 1, pc_write = 1, pc_src = 0, then go to DECODE.
- DECODE: alu_src_a = 0, alu_src_b = 11, alu_op = 00 (computes branch target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 goes to MEM_ADDR.
  - 0110011 goes to EXEC_R.
  - 1100011 goes to BRANCH.
  - Any other value goes to TRAP.
- MEM_ADDR: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Go to MEM_READ for lw, MEM_WRITE for sw. The opcode is still held in IR.
- MEM_READ: mem_req = 1, iord = 1. Go to MEM_WB on mem_ready.
- MEM_WB: reg_write = 1, mem_to_reg = 1.
- MEM_WRITE: mem_req = 1, mem_we = 1, iord = 1. On mem_ready, the instruction retires.
- EXEC_R: alu_src_a = 1, alu_src_b = 00, alu_op = 10. Next state is ALU_WB.
- ALU_WB: reg_write = 1, mem_to_reg = 0.
- BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_src = 1, pc_write = zero.
- Retire states are MEM_WB, ALU_WB, BRANCH, and MEM_WRITE when mem_ready = 1. On leaving a retire state:
  - instret increments by 1 and wraps modulo 2^CNT_W.
  - Next state is FETCH if run = 1, else IDLE.
- TRAP: illegal = 1. Absorbing; only reset exits it. instret does not count the illegal instruction.
- mem_ready is ignored whenever mem_req = 0.
- run is sampled only in IDLE and on retire. Deasserting run mid-instruction completes that instruction.

## Timing
- On rst_n low, immediately and asynchronously: state becomes IDLE, instret = 0, illegal = 0, all outputs 0.
  - mem_req drops immediately; memory must tolerate an abandoned request.
- Release of reset is synchronized externally; the first active edge after release may leave IDLE.
- Outputs are Moore from state, except these, which are combinational in mem_ready or zero:
  - ir_write and pc_write in FETCH
  - pc_write in BRANCH
  - the retire and next-state decision in MEM_WRITE
- With zero-wait memory (mem_ready = 1 whenever mem_req = 1), cycles per instruction are: beq 3, R-type 4, sw 4, lw 5.
- Each cycle with mem_ready = 0 in a memory state adds one cycle.
- instret updates on the clock edge that leaves the retire state, so it is visible in the following FETCH.

## Structure
- Shared package rv_ctrl_pkg holds:
  - the state enum (4-bit)
  - opcode constants OP_LOAD, OP_STORE, OP_RTYPE, OP_BRANCH
  - alu_op constants ALUOP_ADD, ALUOP_BR, ALUOP_FUNCT (also used by the ALU control decoder)
  - alu_src_b encodings
- One sub-module: retire_counter (CNT_W-bit wrapping counter with an increment enable). Everything else stays in the FSM.

## Test plan
- Reset and idle: reset, run = 0 for 5 cycles. Required: state_o = 0, all outputs 0, instret = 0. Then run = 1: FETCH one cycle later with mem_req = 1, iord = 0.
- Zero-wait sequence: add, lw, sw, beq with zero = 1. Required: state traces 1,2,7,8 / 1,2,3,4,5 / 1,2,3,6 / 1,2,9. Instruction cycle counts 4/5/4/3; instret = 4; pc_write = 1 in the BRANCH cycle.
- Memory stalls: lw with mem_ready low 3 cycles in FETCH and 2 in MEM_READ. Required:
  - mem_req stays high throughout both stalls; ir_write pulses exactly once.
  - The instruction takes 10 cycles.
  - A mem_ready pulse in DECODE has no effect.
- Illegal opcode: opcode 0010011. Required: DECODE goes to TRAP, illegal = 1, sticky for 20 cycles; instret unchanged; only rst_n clears it.
- Mid-operation events:
  - Assert rst_n low during MEM_WRITE with mem_req high. Required: mem_req = 0 before the next edge; state_o = 0.
  - Separately, drop run during EXEC_R. Required: ALU_WB completes, then IDLE, with instret incremented.
- Counter wrap: CNT_W = 4, retire 17 instructions. Required: instret = 1.
